// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, register sentinel,
// instruction lengths and the sequential fetch state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] LEN_1  = 4'd1;
    localparam logic [3:0] LEN_2  = 4'd2;
    localparam logic [3:0] LEN_9  = 4'd9;
    localparam logic [3:0] LEN_10 = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// Byte-wide instruction-memory read port: the fetcher is master, memory is slave.
interface fetch_seq_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              mem_err;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata, mem_err
    );
endinterface

// File: rtl/y86_instr_len.sv
// Combinational instruction-format decode from icode: length, which optional
// fields are present, where valC starts, and whether the icode is illegal.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       need_regids,
    output logic       need_valC,
    output logic [3:0] valC_offset,
    output logic       invalid
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        len         = LEN_1;
        need_regids = 1'b0;
        need_valC   = 1'b0;
        valC_offset = 4'd1;
        invalid     = 1'b0;
        case (icode)
            IHALT, INOP, IRET: ;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
                len         = LEN_2;
                need_regids = 1'b1;
            end
            IJXX, ICALL: begin
                len         = LEN_9;
                need_valC   = 1'b1;
            end
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                len         = LEN_10;
                need_regids = 1'b1;
                need_valC   = 1'b1;
                valC_offset = 4'd2;
            end
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Sequential Y86-64 fetch unit: owns the PC, reads the instruction one byte at a
// time over the memory port and presents the decoded fields with a valid pulse.
module fetch_seq_ctrl
    import y86_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    fetch_seq_ctrl_if.master  mem,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [ADDR_W-1:0] valC,
    output logic [ADDR_W-1:0] valP,
    output logic              instr_valid,
    output logic              instr_invalid,
    output logic              imem_error,
    output logic              halted,
    output logic              busy
);

    fetch_state_t      state, state_n;
    logic [3:0]        byte_idx, byte_idx_n;
    logic [ADDR_W-1:0] pc_n, valC_n, valP_n, addr_n;
    logic [3:0]        icode_n, ifun_n, rA_n, rB_n;
    logic              req_n, instr_valid_n, instr_invalid_n, imem_error_n, halted_n, busy_n;

    logic [3:0] lookup_icode, len, valc_offset;
    logic       need_regids, need_valc, invalid;
    logic [2:0] valc_byte;

    // Byte 0 is decoded straight off the bus; later bytes use the captured icode.
    assign lookup_icode = (byte_idx == 4'd0) ? mem.mem_rdata[7:4] : icode;
    assign valc_byte    = 3'(byte_idx - valc_offset);

    y86_instr_len u_len (
        .icode       (lookup_icode),
        .len         (len),
        .need_regids (need_regids),
        .need_valC   (need_valc),
        .valC_offset (valc_offset),
        .invalid     (invalid)
    );

    always_comb begin
        state_n         = state;
        byte_idx_n      = byte_idx;
        pc_n            = pc;
        icode_n         = icode;
        ifun_n          = ifun;
        rA_n            = rA;
        rB_n            = rB;
        valC_n          = valC;
        valP_n          = valP;
        req_n           = mem.mem_req;
        addr_n          = mem.mem_addr;
        instr_valid_n   = 1'b0;
        instr_invalid_n = instr_invalid;
        imem_error_n    = imem_error;
        halted_n        = halted;

        case (state)
            S_IDLE: begin
                if (pc_load) pc_n = pc_in;
                if (start) begin
                    instr_invalid_n = 1'b0;
                    imem_error_n    = 1'b0;
                    byte_idx_n      = 4'd0;
                    req_n           = 1'b1;
                    addr_n          = pc_load ? pc_in : pc;
                    state_n         = S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_ack) begin
                    if (mem.mem_err) begin
                        imem_error_n  = 1'b1;
                        valP_n        = pc + ADDR_W'(1);
                        req_n         = 1'b0;
                        instr_valid_n = 1'b1;
                        state_n       = S_DONE;
                    end else begin
                        if (byte_idx == 4'd0) begin
                            icode_n         = mem.mem_rdata[7:4];
                            ifun_n          = mem.mem_rdata[3:0];
                            rA_n            = RNONE;
                            rB_n            = RNONE;
                            valC_n          = '0;
                            instr_invalid_n = invalid;
                        end else if (need_regids && byte_idx == 4'd1) begin
                            rA_n = mem.mem_rdata[7:4];
                            rB_n = mem.mem_rdata[3:0];
                        end else if (need_valc) begin
                            valC_n[8*valc_byte +: 8] = mem.mem_rdata;
                        end

                        if (byte_idx + 4'd1 == len) begin
                            valP_n        = pc + ADDR_W'(len);
                            req_n         = 1'b0;
                            instr_valid_n = 1'b1;
                            state_n       = S_DONE;
                        end else begin
                            byte_idx_n = byte_idx + 4'd1;
                            addr_n     = pc + ADDR_W'(byte_idx + 4'd1);
                        end
                    end
                end
            end
            S_DONE: begin
                if (icode == IHALT && !imem_error) begin
                    halted_n = 1'b1;
                    state_n  = S_HALT;
                end else begin
                    state_n  = S_IDLE;
                end
            end
            S_HALT: ;
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            byte_idx      <= 4'd0;
            pc            <= '0;
            icode         <= 4'h0;
            ifun          <= 4'h0;
            rA            <= RNONE;
            rB            <= RNONE;
            valC          <= '0;
            valP          <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_addr  <= '0;
            instr_valid   <= 1'b0;
            instr_invalid <= 1'b0;
            imem_error    <= 1'b0;
            halted        <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            byte_idx      <= byte_idx_n;
            pc            <= pc_n;
            icode         <= icode_n;
            ifun          <= ifun_n;
            rA            <= rA_n;
            rB            <= rB_n;
            valC          <= valC_n;
            valP          <= valP_n;
            mem.mem_req   <= req_n;
            mem.mem_addr  <= addr_n;
            instr_valid   <= instr_valid_n;
            instr_invalid <= instr_invalid_n;
            imem_error    <= imem_error_n;
            halted        <= halted_n;
            busy          <= busy_n;
        end
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: a wait-state memory responder, a
// per-cycle compare against a timing/field model, directed cases and random fetches.
module tb_fetch_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        pc_load = 1'b0;
    logic [63:0] pc_in = '0;
    logic [63:0] pc, valC, valP;
    logic [3:0]  icode, ifun, rA, rB;
    logic        instr_valid, instr_invalid, imem_error, halted, busy;

    fetch_seq_ctrl_if #(.ADDR_W(64)) mem_bus ();

    fetch_seq_ctrl #(.ADDR_W(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pc_load       (pc_load),
        .pc_in         (pc_in),
        .mem           (mem_bus),
        .pc            (pc),
        .icode         (icode),
        .ifun          (ifun),
        .rA            (rA),
        .rB            (rB),
        .valC          (valC),
        .valP          (valP),
        .instr_valid   (instr_valid),
        .instr_invalid (instr_invalid),
        .imem_error    (imem_error),
        .halted        (halted),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction length by icode; illegal icodes count as one byte.
    int len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model of the fetch in flight: when it starts, how many bytes, waits, results.
    bit          cmp_en = 0;
    bit          f_active = 0;
    int          f_T, f_n, f_w = 0;
    logic [63:0] f_base, f_valp, f_valc;
    logic [3:0]  f_icode, f_ifun, f_ra, f_rb;
    bit          f_err, f_inv, f_halt;
    logic [63:0] exp_pc = '0;
    logic [7:0]  fb [10];
    logic [7:0]  mem_bytes [logic [63:0]];
    bit          err_en = 0;
    logic [63:0] err_addr = '0;
    int          wait_cnt = 0;
    bit          noise = 0;

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 8'h00;
        mem_bus.mem_err   = 1'b0;
    end

    // Memory: acks after f_w wait cycles per byte, flags err on err_addr.
    always @(negedge clk) begin
        if (mem_bus.mem_req === 1'b1) begin
            if (wait_cnt >= f_w) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = mem_bytes.exists(mem_bus.mem_addr) ? mem_bytes[mem_bus.mem_addr] : 8'h00;
                mem_bus.mem_err   = err_en && (mem_bus.mem_addr == err_addr);
                wait_cnt = 0;
            end else begin
                mem_bus.mem_ack = 1'b0;
                mem_bus.mem_err = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_bus.mem_ack = 1'b0;
            mem_bus.mem_err = 1'b0;
            wait_cnt = 0;
        end
    end

    // Per-cycle compare: request window, address per byte, valid pulse, flags, fields.
    int rel, nn;
    always @(negedge clk) begin
        if (cmp_en) begin
            if (!f_active) begin
                check("idle_mem_req", mem_bus.mem_req, 0);
                check("idle_instr_valid", instr_valid, 0);
                check("idle_halted", halted, 0);
                check("idle_busy", busy, 0);
            end else begin
                rel = cyc - f_T;
                nn  = f_n * (f_w + 1);
                check("mem_req", mem_bus.mem_req, (rel >= 0 && rel < nn));
                if (rel >= 0 && rel < nn) begin
                    check("mem_addr", mem_bus.mem_addr, f_base + 64'(rel / (f_w + 1)));
                    check("pc_during_fetch", pc, f_base);
                end
                check("instr_valid", instr_valid, (rel == nn));
                check("busy", busy, ((rel >= 0 && rel <= nn) || (f_halt && rel > nn)));
                check("halted", halted, (f_halt && rel > nn));
                if (rel >= 0) begin
                    check("instr_invalid", instr_invalid, (rel >= nn) ? f_inv : 1'b0);
                    check("imem_error", imem_error, (rel >= nn) ? f_err : 1'b0);
                end
                if (rel >= nn) begin
                    check("icode", icode, f_icode);
                    check("ifun", ifun, f_ifun);
                    check("valP", valP, f_valp);
                    if (!f_err) begin
                        check("rA", rA, f_ra);
                        check("rB", rB, f_rb);
                        check("valC", valC, f_valc);
                    end
                end
            end
        end
    end

    // Place fb[] at the fetch address, derive expected results, pulse start.
    task automatic launch(input bit load, input logic [63:0] pin, input int w, input int eb);
        logic [63:0] base;
        logic [3:0]  ic;
        int          ln;
        @(negedge clk);
        base = load ? pin : exp_pc;
        for (int i = 0; i < 10; i++) mem_bytes[base + 64'(i)] = fb[i];
        ic       = fb[0][7:4];
        ln       = len_tab[ic];
        f_err    = (eb >= 1 && eb < ln);
        f_n      = f_err ? eb + 1 : ln;
        f_valp   = base + 64'(f_err ? 1 : ln);
        f_icode  = ic;
        f_ifun   = fb[0][3:0];
        f_ra     = (ln == 2 || ln == 10) ? fb[1][7:4] : 4'hF;
        f_rb     = (ln == 2 || ln == 10) ? fb[1][3:0] : 4'hF;
        f_valc   = '0;
        if (ln >= 9)
            for (int j = 0; j < 8; j++) f_valc[8*j +: 8] = fb[ln - 8 + j];
        f_inv    = (ic > 4'hB);
        f_halt   = (ic == 4'h0) && !f_err;
        err_en   = f_err;
        err_addr = base + 64'(eb);
        f_w      = w;
        f_base   = base;
        exp_pc   = base;
        f_T      = cyc + 1;
        f_active = 1;
        start    = 1'b1;
        pc_load  = load;
        pc_in    = pin;
        @(negedge clk);
        start    = 1'b0;
        pc_load  = 1'b0;
    endtask

    // Wait (bounded) for the valid pulse; optionally toggle ignored inputs meanwhile.
    task automatic finish_fetch(output int vcyc);
        int k = 0;
        while (instr_valid !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
            if (noise && instr_valid !== 1'b1) begin
                start   = 1'($urandom_range(0, 1));
                pc_load = 1'($urandom_range(0, 1));
                pc_in   = {$urandom, $urandom};
            end
        end
        start   = 1'b0;
        pc_load = 1'b0;
        vcyc    = cyc;
        check("valid_within_budget", (k < 400), 1);
        @(negedge clk);
    endtask

    function automatic void set_bytes(input logic [79:0] v);
        for (int i = 0; i < 10; i++) fb[i] = v[79 - 8*i -: 8];
    endfunction

    initial begin
        int vc;
        #500000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int vc;
        logic [63:0] r;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_bus.mem_req, 0);
        check("rst_mem_addr", mem_bus.mem_addr, 0);
        check("rst_pc", pc, 0);
        check("rst_rA", rA, 4'hF);
        check("rst_rB", rB, 4'hF);
        check("rst_icode", icode, 0);
        check("rst_valC", valC, 0);
        check("rst_valP", valP, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {instr_valid, instr_invalid, imem_error, halted}, 0);
        reset  = 1'b0;
        cmp_en = 1;

        // irmovq $5, %rdx at 0x100, zero-wait
        set_bytes(80'h30_F2_05_00_00_00_00_00_00_00);
        launch(1, 64'h100, 0, -1);
        finish_fetch(vc);
        check("irmovq_latency", vc, f_T + 10);
        check("irmovq_icode", icode, 4'h3);
        check("irmovq_rA", rA, 4'hF);
        check("irmovq_rB", rB, 4'h2);
        check("irmovq_valC", valC, 64'h5);
        check("irmovq_valP", valP, 64'h10A);

        // jXX at 0x20 with two wait cycles per byte
        set_bytes(80'h73_34_12_00_00_00_00_00_00_00);
        launch(1, 64'h20, 2, -1);
        finish_fetch(vc);
        check("jxx_latency", vc, f_T + 27);
        check("jxx_valC", valC, 64'h1234);
        check("jxx_rArB", {rA, rB}, 8'hFF);
        check("jxx_valP", valP, 64'h29);

        // Illegal icode, then a nop from the same PC clears the flag
        set_bytes(80'hC0_00_00_00_00_00_00_00_00_00);
        launch(1, 64'h60, 0, -1);
        finish_fetch(vc);
        check("inv_flag", instr_invalid, 1);
        check("inv_valP", valP, 64'h61);
        check("inv_back_idle", busy, 0);
        set_bytes(80'h10_00_00_00_00_00_00_00_00_00);
        launch(0, 64'h0, 1, -1);
        finish_fetch(vc);
        check("inv_cleared", instr_invalid, 0);
        check("nop_valP", valP, 64'h61);

        // rmmovq with a memory error on byte 3
        set_bytes(80'h40_12_78_56_34_12_00_00_00_00);
        launch(1, 64'h200, 0, 3);
        finish_fetch(vc);
        check("err_flag", imem_error, 1);
        check("err_valP", valP, 64'h201);
        check("err_latency", vc, f_T + 4);

        // Random fetches with noise on ignored inputs
        noise = 1;
        for (int n = 0; n < 40; n++) begin
            logic [3:0] ic;
            int ln, eb, w;
            bit ld;
            if ($urandom_range(0, 3) == 0) begin
                r = {$urandom, $urandom};
                @(negedge clk);
                pc_load = 1'b1;
                pc_in   = r;
                exp_pc  = r;
                @(negedge clk);
                pc_load = 1'b0;
                check("pc_load_idle", pc, r);
            end
            ic = 4'($urandom_range(1, 15));
            fb[0] = {ic, 4'($urandom_range(0, 15))};
            for (int i = 1; i < 10; i++) fb[i] = 8'($urandom);
            ln = len_tab[ic];
            eb = (ln > 1 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, ln - 1)) : -1;
            w  = $urandom_range(0, 2);
            ld = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFA : {$urandom, $urandom};
            launch(ld, r, w, eb);
            finish_fetch(vc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        noise = 0;

        // Reset asserted while byte 4 is being requested
        set_bytes(80'h30_F3_11_22_33_44_55_66_77_88);
        launch(1, 64'h300, 0, -1);
        repeat (4) @(negedge clk);
        check("abort_in_req", mem_bus.mem_req, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        f_active = 0;
        exp_pc   = '0;
        check("abort_mem_req", mem_bus.mem_req, 0);
        check("abort_pc", pc, 0);
        check("abort_busy", busy, 0);
        check("abort_valC", valC, 0);
        check("abort_rA", rA, 4'hF);
        @(negedge clk);
        reset = 1'b0;

        // pc_load together with start after reset
        set_bytes(80'h60_12_00_00_00_00_00_00_00_00);
        launch(1, 64'h40, 0, -1);
        finish_fetch(vc);
        check("post_rst_pc", pc, 64'h40);
        check("post_rst_rArB", {rA, rB}, 8'h12);
        check("post_rst_valP", valP, 64'h42);

        // halt: sticky, ignores start/pc_load until reset
        set_bytes(80'h00_00_00_00_00_00_00_00_00_00);
        launch(1, 64'h80, 0, -1);
        finish_fetch(vc);
        check("halt_valP", valP, 64'h81);
        @(negedge clk);
        start   = 1'b1;
        pc_load = 1'b1;
        pc_in   = 64'h999;
        repeat (3) @(negedge clk);
        start   = 1'b0;
        pc_load = 1'b0;
        check("halt_sticky", halted, 1);
        check("halt_pc_kept", pc, 64'h80);
        check("halt_no_req", mem_bus.mem_req, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        f_active = 0;
        exp_pc   = '0;
        check("halt_cleared", halted, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Multi-cycle instruction fetcher for the sequential Y86-64 core. It is the consumer of the next-PC value that the PC-update stage produces.
- Holds the architectural PC register and loads it from the PC-update result.
- Reads the instruction at PC one byte at a time over a req/ack byte-wide instruction-memory port.
- Presents icode, ifun, rA, rB, valC and valP to decode/execute with a one-cycle valid pulse.

Parameters:
- ADDR_W, 64, width of PC, memory address, valC and valP.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request fetch of the instruction at the current PC; sampled in IDLE only.
- pc_load  in  1  load pc_in into the PC register; honoured in IDLE only.
- pc_in  in  ADDR_W  next PC from the PC-update stage.
- mem_req  out  1  byte read request.
- mem_addr  out  ADDR_W  byte address; stable while mem_req=1.
- mem_ack  in  1  byte available on mem_rdata this cycle.
- mem_rdata  in  8  read byte.
- mem_err  in  1  address error, qualified by mem_ack.
- pc  out  ADDR_W  current PC register.
- icode  out  4  instruction code.
- ifun  out  4  function code.
- rA  out  4  register A (0xF when absent).
- rB  out  4  register B (0xF when absent).
- valC  out  ADDR_W  constant word, little-endian (0 when absent).
- valP  out  ADDR_W  pc + instruction length.
- instr_valid  out  1  one-cycle pulse: fields valid.
- instr_invalid  out  1  icode > 0xB; sticky until next start.
- imem_error  out  1  mem_err seen during fetch; sticky until next start.
- halted  out  1  halt instruction fetched; sticky until reset.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - state IDLE.
  - pc, valC, valP = 0.
  - icode, ifun = 0; rA, rB = 0xF.
  - All 1-bit outputs 0, including mem_req. mem_addr = 0.
- All outputs are registered.
- States: IDLE, REQ, DONE, HALT.
- IDLE:
  - pc_load=1 sets pc <= pc_in.
  - start=1 clears instr_invalid/imem_error, sets byte_idx=0, goes to REQ.
  - If pc_load and start are both 1, the fetch uses pc_in: mem_addr = pc_in, pc = pc_in.
- REQ:
  - mem_req=1 and mem_addr = pc + byte_idx, held until mem_ack.
  - On each mem_ack, the byte is captured and byte_idx increments.
  - Byte 0: icode = rdata[7:4], ifun = rdata[3:0]; length is taken from the table below.
  - Register byte (byte 1, when present): rA = rdata[7:4], rB = rdata[3:0].
  - valC bytes are assembled little-endian. The first valC byte sits at offset 1 for jXX/call and offset 2 for irmovq/rmmovq/mrmovq.
  - When the final byte is acked: go to DONE and deassert mem_req on the next edge.
  - mem_ack with mem_err=1: set imem_error, go to DONE immediately, valP = pc + 1.
  - icode > 0xB: set instr_invalid, length 1, go to DONE.
  - pc_load and start are ignored in REQ.
- Lengths:
  - icode 0, 1, 9: 1 byte.
  - icode 2, 6, A, B: 2 bytes.
  - icode 7, 8: 9 bytes.
  - icode 3, 4, 5: 10 bytes.
- DONE:
  - instr_valid=1 for exactly this cycle; valP = pc + length (modulo 2^ADDR_W, wrap permitted).
  - Next state is HALT if icode==0 and there is no error; otherwise IDLE.
- HALT:
  - halted=1; start and pc_load are ignored. Only reset exits.
- Latency: start sampled at edge T, so mem_req is high from T+1. With zero-wait ack, an n-byte instruction asserts instr_valid in cycle T+n+1. Each extra wait cycle adds 1.
- Output hold: fields hold their values after DONE until the next fetch's byte 0 is captured.
- Reset mid-fetch: synchronous abort. mem_req is low from the edge where reset is sampled, and all registers return to reset values.

Decomposition:
- Package y86_pkg:
  - icode constants (IHALT..IPOPQ).
  - RNONE = 4'hF.
  - State enum.
  - Length constants.
- Sub-module y86_instr_len: combinational icode -> {len[3:0], need_regids, need_valC, valC_offset, invalid}. It is reused later by the pipelined fetch.

Test Plan:
- Reset, then pc_load with pc_in=0x100 and start; memory holds 30 F2 05 00 00 00 00 00 00 00 with ack every cycle -> 10 mem_req cycles, addresses 0x100..0x109; icode=3, ifun=0, rA=F, rB=2, valC=5, valP=0x10A; instr_valid one pulse at T+11.
- jXX at 0x20: 73 34 12 00 00 00 00 00 00, ack with 2 wait cycles per byte -> mem_addr is stable while waiting; valC=0x1234, rA=rB=F, valP=0x29.
- Byte 0 = 0x00 (halt) -> valP = pc+1; halted=1 after DONE; subsequent start and pc_load are ignored; reset clears halted.
- Byte 0 = 0xC0 -> instr_invalid=1, valP = pc+1, returns to IDLE; the next start clears instr_invalid.
- mem_err with ack on byte 3 of rmmovq -> imem_error=1, instr_valid pulse, valP = pc+1.
- Reset asserted mid-REQ on byte 4 -> mem_req is 0 and pc=0 in the next cycle; a fetch from pc_in=0x40 after reset works normally; also check that pc_load+start together fetch from pc_in.
